// File: rtl/mac_array_ctrl_if.sv
// rtl/mac_array_ctrl_if.sv - command, operand-buffer and mac_array signals of mac_array_ctrl
// The slave modport is the sequencer's view; the master modport is its environment.
interface mac_array_ctrl_if #(
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int addr_w  = 11,
  parameter int len_w   = 8
) ();
  logic                   start;
  logic                   mode;
  logic [len_w-1:0]       len;
  logic [addr_w-1:0]      w_base;
  logic [addr_w-1:0]      x_base;
  logic                   rd_en;
  logic [addr_w-1:0]      rd_addr;
  logic [bw*row-1:0]      rd_data;
  logic [2:0]             inst_w;
  logic [bw*row-1:0]      in_w;
  logic [psum_bw*col-1:0] in_n;
  logic [col-1:0]         valid;
  logic                   busy;
  logic                   done;
  logic                   err;

  modport master (
    output start, mode, len, w_base, x_base, rd_data, valid,
    input  rd_en, rd_addr, inst_w, in_w, in_n, busy, done, err
  );

  modport slave (
    input  start, mode, len, w_base, x_base, rd_data, valid,
    output rd_en, rd_addr, inst_w, in_w, in_n, busy, done, err
  );
endinterface

// File: rtl/mac_array_ctrl.sv
// rtl/mac_array_ctrl.sv - kernel-load / execute / drain sequencer for one mac_array tile
// Stage instructions are registered once so inst_w lines up with the synchronous-read rd_data.
module mac_array_ctrl #(
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int addr_w  = 11,
  parameter int len_w   = 8
) (
  input logic          clk,
  input logic          reset,
  mac_array_ctrl_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_KLOAD, S_KFLUSH, S_EXEC, S_DRAIN, S_DONE
  } state_t;

  localparam int               TMO_W    = len_w + 2;
  localparam logic [len_w-1:0] ROW_LAST = len_w'(row - 1);
  localparam logic [len_w-1:0] COL_LAST = len_w'(col - 1);
  // Last DRAIN cycle index before the timeout fires is row+col+len+7.
  localparam logic [TMO_W-1:0] TMO_BASE = TMO_W'(row + col + 7);

  state_t              r_state;
  state_t              w_next;
  logic                r_mode;
  logic [len_w-1:0]    r_len;
  logic [addr_w-1:0]   r_w_base;
  logic [addr_w-1:0]   r_x_base;
  logic [len_w-1:0]    r_idx;
  logic [len_w:0]      r_vcnt;
  logic [TMO_W-1:0]    r_tcnt;
  logic [2:0]          r_inst;
  logic                r_err;

  logic                w_accept;
  logic                w_vdone;
  logic                w_tmo;
  logic [len_w-1:0]    w_len_last;
  logic                w_rd_en;
  logic [addr_w-1:0]   w_rd_addr;
  logic [2:0]          w_stage;
  logic                w_busy;
  logic                w_done;
  logic [bw*row-1:0]   w_in_w;
  logic [psum_bw*col-1:0] w_in_n;
  logic                w_unused_valid;

  assign w_accept   = (r_state == S_IDLE) && bus.start;
  assign w_vdone    = (r_vcnt == {1'b0, r_len});
  assign w_tmo      = (r_tcnt == (TMO_BASE + TMO_W'(r_len)));
  assign w_len_last = r_len - len_w'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (bus.start) w_next = S_KLOAD;
      S_KLOAD:  if (r_idx == ROW_LAST) w_next = S_KFLUSH;
      S_KFLUSH: if (r_idx == COL_LAST) w_next = (r_len != '0) ? S_EXEC : S_DONE;
      S_EXEC:   if (r_idx == w_len_last) w_next = S_DRAIN;
      S_DRAIN:  if (w_vdone || w_tmo) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_rd_en   = 1'b0;
    w_rd_addr = '0;
    w_stage   = 3'b000;
    w_busy    = 1'b0;
    w_done    = 1'b0;
    case (r_state)
      S_KLOAD: begin
        w_rd_en   = 1'b1;
        w_rd_addr = r_w_base + addr_w'(r_idx);
        w_stage   = {r_mode, 2'b01};
        w_busy    = 1'b1;
      end
      S_KFLUSH: begin
        w_stage = {r_mode, 2'b00};
        w_busy  = 1'b1;
      end
      S_EXEC: begin
        w_rd_en   = 1'b1;
        w_rd_addr = r_x_base + addr_w'(r_idx);
        w_stage   = {r_mode, 2'b10};
        w_busy    = 1'b1;
      end
      S_DRAIN: begin
        w_stage = {r_mode, 2'b00};
        w_busy  = 1'b1;
      end
      S_DONE: begin
        w_stage = {r_mode, 2'b00};
        w_busy  = 1'b1;
        w_done  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mode   <= 1'b0;
      r_len    <= '0;
      r_w_base <= '0;
      r_x_base <= '0;
      r_idx    <= '0;
      r_vcnt   <= '0;
      r_tcnt   <= '0;
      r_inst   <= 3'b000;
      r_err    <= 1'b0;
    end else begin
      r_inst <= w_stage;
      r_idx  <= (w_next != r_state) ? '0 : r_idx + len_w'(1);
      if (w_accept) begin
        r_mode   <= bus.mode;
        r_len    <= bus.len;
        r_w_base <= bus.w_base;
        r_x_base <= bus.x_base;
        r_err    <= 1'b0;
      end else if (r_state == S_DRAIN && !w_vdone && w_tmo) begin
        r_err <= 1'b1;
      end
      // Saturating count: pulses beyond len never push the drain exit further.
      if (w_accept) begin
        r_vcnt <= '0;
      end else if ((r_state == S_EXEC || r_state == S_DRAIN) && bus.valid[col-1] && !w_vdone) begin
        r_vcnt <= r_vcnt + (len_w+1)'(1);
      end
      if (w_next == S_DRAIN && r_state != S_DRAIN) begin
        r_tcnt <= '0;
      end else if (r_state == S_DRAIN) begin
        r_tcnt <= r_tcnt + TMO_W'(1);
      end
    end
  end

  assign w_in_w         = (r_inst[1:0] != 2'b00) ? bus.rd_data : '0;
  assign w_in_n         = '0;
  assign w_unused_valid = ^bus.valid[col-2:0];

  assign bus.rd_en   = w_rd_en;
  assign bus.rd_addr = w_rd_addr;
  assign bus.inst_w  = r_inst;
  assign bus.in_w    = w_in_w;
  assign bus.in_n    = w_in_n;
  assign bus.busy    = w_busy;
  assign bus.done    = w_done;
  assign bus.err     = r_err;
endmodule

// File: tb/tb_mac_array_ctrl.sv
// tb/tb_mac_array_ctrl.sv - scoreboard bench for mac_array_ctrl
// Per-cycle expectations are queued at each start; valid[7] comes from a 16-cycle delay of inst_w[1].
module tb_mac_array_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   n_done = 0;
  logic valid_en;
  logic [15:0] r_vsh = '0;

  typedef struct {
    bit          inst_chk;
    logic [2:0]  inst;
    logic        en;
    logic [10:0] addr;
    logic        busy;
    logic        done;
    bit          err_chk;
    logic        err;
    logic [31:0] inw;
  } exp_t;

  exp_t q_exp[$];
  exp_t m_e;

  mac_array_ctrl_if u_if ();

  mac_array_ctrl u_dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (u_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_f(input logic [10:0] a);
    return {a, ~a, a[9:0] ^ 10'h2A5};
  endfunction

  always @(posedge clk) u_if.rd_data <= u_if.rd_en ? mem_f(u_if.rd_addr) : $urandom;
  always @(posedge clk) r_vsh <= {r_vsh[14:0], u_if.inst_w[1]};
  assign u_if.valid = {valid_en & r_vsh[15], 7'b0};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (u_if.done === 1'b1) n_done++;
    if (q_exp.size() != 0) begin
      m_e = q_exp.pop_front();
      check("busy", u_if.busy, m_e.busy);
      check("rd_en", u_if.rd_en, m_e.en);
      if (m_e.en) check("rd_addr", u_if.rd_addr, m_e.addr);
      check("done", u_if.done, m_e.done);
      if (m_e.inst_chk) begin
        check("inst_w", u_if.inst_w, m_e.inst);
        check("in_w", u_if.in_w, m_e.inw);
      end
      if (m_e.err_chk) check("err", u_if.err, m_e.err);
    end
  end

  task automatic push_script(input int len, input logic [10:0] wb, input logic [10:0] xb, input logic m);
    exp_t e;
    int   last;
    last = (len == 0) ? 18 : 17 + len;
    for (int k = 0; k <= last; k++) begin
      e = '{default: '0};
      e.inst_chk = (k > 0) && !(len == 0 && k == 18);
      e.err_chk  = (k > 0);
      e.busy     = (k >= 1) && (k <= 17 || len != 0);
      e.done     = (len == 0 && k == 17);
      if (k >= 1 && k <= 8) begin
        e.en = 1'b1; e.addr = wb + 11'(k - 1);
      end
      if (len != 0 && k >= 17 && k <= 16 + len) begin
        e.en = 1'b1; e.addr = xb + 11'(k - 17);
      end
      if (k >= 2 && k <= 9) begin
        e.inst = {m, 2'b01}; e.inw = mem_f(wb + 11'(k - 2));
      end else if (k >= 10 && k <= 17) begin
        e.inst = {m, 2'b00};
      end else if (k >= 18) begin
        e.inst = {m, 2'b10}; e.inw = mem_f(xb + 11'(k - 18));
      end
      q_exp.push_back(e);
    end
  endtask

  task automatic run_cmd(input int len, input logic [10:0] wb, input logic [10:0] xb,
                         input logic m, input bit timeout, input bit glitch);
    int t0, d0, exp_off;
    bit seen;
    valid_en = !timeout;
    @(posedge clk); #1;
    u_if.start = 1'b1; u_if.len = 8'(len); u_if.w_base = wb; u_if.x_base = xb; u_if.mode = m;
    t0 = cyc; d0 = n_done;
    push_script(len, wb, xb, m);
    @(posedge clk); #1;
    u_if.start = 1'b0;
    u_if.len = 8'($urandom); u_if.w_base = 11'($urandom); u_if.x_base = 11'($urandom);
    u_if.mode = 1'($urandom);
    if (glitch) begin
      repeat (16) @(posedge clk);
      #1 u_if.start = 1'b1;
      @(posedge clk); #1 u_if.start = 1'b0;
    end
    for (int i = 0; i < 200 && q_exp.size() != 0; i++) @(negedge clk);
    if (len != 0) begin
      seen = 0;
      for (int i = 0; i < 300; i++) begin
        if (u_if.done === 1'b1) begin
          seen = 1;
          break;
        end
        @(negedge clk);
      end
      if (!seen) begin
        check("done_seen", 0, 1);
      end else begin
        exp_off = timeout ? 41 + 2 * len : 35 + len;
        check("done_cyc", cyc - t0, exp_off);
        check("err_at_done", u_if.err, timeout);
        if (glitch) u_if.start = 1'b1;
        @(posedge clk); #1 u_if.start = 1'b0;
        @(negedge clk);
        check("busy_after_done", u_if.busy, 0);
      end
    end
    repeat (20) @(negedge clk);
    check("done_count", n_done - d0, 1);
    check("err_sticky", u_if.err, timeout);
    check("idle_busy", u_if.busy, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    valid_en = 1'b1;
    u_if.start = 1'b0; u_if.mode = 1'b0; u_if.len = '0; u_if.w_base = '0; u_if.x_base = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rd_en", u_if.rd_en, 0);
    check("rst_rd_addr", u_if.rd_addr, 0);
    check("rst_inst_w", u_if.inst_w, 0);
    check("rst_in_w", u_if.in_w, 0);
    check("rst_in_n", u_if.in_n, 0);
    check("rst_busy", u_if.busy, 0);
    check("rst_done", u_if.done, 0);
    check("rst_err", u_if.err, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    run_cmd(4, 11'h010, 11'h100, 1'b0, 0, 0);
    run_cmd(0, 11'h020, 11'h200, 1'b1, 0, 0);
    run_cmd(2, 11'h7FE, 11'h7FF, 1'b0, 0, 0);
    run_cmd(5, 11'h040, 11'h300, 1'b1, 0, 1);
    run_cmd(3, 11'h050, 11'h350, 1'b0, 1, 0);
    run_cmd(6, 11'h060, 11'h400, 1'b0, 0, 0);

    // Abort in KFLUSH: outputs must drop with reset, not at the next edge.
    valid_en = 1'b1;
    @(posedge clk); #1;
    u_if.start = 1'b1; u_if.len = 8'd4; u_if.w_base = 11'h010; u_if.x_base = 11'h100; u_if.mode = 1'b1;
    @(posedge clk); #1 u_if.start = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("abort_rd_en", u_if.rd_en, 0);
    check("abort_rd_addr", u_if.rd_addr, 0);
    check("abort_inst_w", u_if.inst_w, 0);
    check("abort_in_w", u_if.in_w, 0);
    check("abort_busy", u_if.busy, 0);
    check("abort_done", u_if.done, 0);
    check("abort_err", u_if.err, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    run_cmd(4, 11'h010, 11'h100, 1'b0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
